// File: rtl/uart_rx_match.sv
// uart_rx_match: 8N1 UART receiver with an in-line "Hello World!\n" sequence matcher
// Ports: clk/rst (async active-high) | rx serial in, idle high |
//        data last good byte | rcv good-byte strobe | frame_err bad-stop strobe |
//        match greeting-complete strobe | busy frame in progress
module uart_rx_match #(
  parameter int BAUD = 104,
  parameter int HALF = BAUD / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       frame_err,
  output logic       match,
  output logic       busy
);
  localparam int CW = $clog2(BAUD) + 1;
  localparam logic [103:0] MSG = "Hello World!\n";
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, data_q, data_d, rom_b;
  logic [3:0] idx_q, idx_d;
  logic rcv_q, rcv_d, ferr_q, ferr_d, match_q, match_d, busy_q, busy_d;
  logic s1_q, s2_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rcv_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (!s2_q) begin
        state_d = START;
        cnt_d   = CW'(HALF - 1);
      end
      START: if (cnt_q == '0) begin
        state_d = s2_q ? IDLE : DATA;
        bit_d   = '0;
        cnt_d   = CW'(BAUD - 1);
      end
      DATA: if (cnt_q == '0) begin
        sh_d    = {s2_q, sh_q[7:1]};
        bit_d   = bit_q + 3'd1;
        cnt_d   = CW'(BAUD - 1);
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == '0) begin
        state_d = IDLE;
        rcv_d   = s2_q;
        ferr_d  = !s2_q;
        data_d  = s2_q ? sh_q : data_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // ROM entry for the current match position; first character sits in the MSBs
    rom_b   = MSG[8*(12-int'(idx_q)) +: 8];
    // 'H' appears only at position 0, so restarting at 1 on a stray 'H' is exact
    idx_d   = ferr_q ? 4'd0 :
              !rcv_q ? idx_q :
              (data_q == rom_b) ? ((idx_q == 4'd12) ? 4'd0 : idx_q + 4'd1) :
              (data_q == "H") ? 4'd1 : 4'd0;
    match_d = rcv_q && (data_q == rom_b) && (idx_q == 4'd12);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      s1_q    <= rx;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rcv_q   <= rcv_d;
      ferr_q  <= ferr_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
    end
  end
  assign data      = data_q;
  assign rcv       = rcv_q;
  assign frame_err = ferr_q;
  assign match     = match_q;
  assign busy      = busy_q;
endmodule
